edge_monitor: RTL and testbench
===============================

# edge_monitor

Multi-channel, clocked edge-event monitor: the parametrised successor of our per-signal posedge/negedge response modules. Each channel synchronises an asynchronous input, detects rising, falling or both edges under a per-channel mode, and keeps a sticky pending flag, a saturating event count and an overflow flag until software acknowledges. A combined interrupt and per-channel registered inverted levels sit alongside, so testbenches and the main model can react to events without `always @(edge)` blocks.

## Interface
- CHANNELS, 4, number of monitored inputs (1..32)
- CNT_W, 8, event counter width per channel (2..16)
- TS_W, 16, timestamp width (used only with EDGE_MONITOR_TIMESTAMP_EN)

- clk  in  1  sole clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- sig_in  in  CHANNELS  asynchronous monitored inputs
- mode  in  2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- ack  in  CHANNELS  per-channel clear strobe, one cycle
- pending  out  CHANNELS  sticky event flag
- count  out  CHANNELS*CNT_W  saturating event count, channel i at [i*CNT_W +: CNT_W]
- overflow  out  CHANNELS  sticky: edge arrived while count saturated
- irq  out  1  OR of pending
- level_n  out  CHANNELS  registered inverse of synchronised input
- ts  out  CHANNELS*TS_W  timestamp of first unacknowledged event

## Operation
- Per channel: two-flop synchroniser s1→s2, plus prev = s2 delayed one cycle.
- Rise = s2 & ~prev; fall = ~s2 & prev; edge = (rise & mode[0]) | (fall & mode[1]).
- prev updates every cycle regardless of mode; mode changes take effect on the next edge.
- On edge without ack: pending←1; count←count+1 unless all-ones; if count was all-ones, overflow←1 and count stays.
- ack without edge: pending, count, overflow ←0.
- ack and edge same cycle: acknowledge clears old state, new event recorded: pending=1, count=1, overflow=0.
- ack on a non-pending channel: harmless, clears to 0.
- level_n = ~s2.
- irq = |pending, combinational from registers (no extra latency).

## Timing
- Reset (synchronous): s1, s2, prev all load current sig_in, so an input already high at release produces no spurious edge. pending=0, count=0, overflow=0, irq=0, ts=0, level_n=~sig_in sampled at the reset edge.
- Latency: sig_in change set up before edge k → s1 at k, s2 at k+1, detection and pending/count update at edge k+2; visible in the cycle after edge k+2.
- level_n follows sig_in after edge k+1.
- Pulses shorter than one clock period may be lost. Pulses of at least two periods are guaranteed detected, both edges.
- Reset asserted mid-operation discards all pending state within that one edge. An edge in flight in the synchroniser is lost.

## Configuration
- EDGE_MONITOR_TIMESTAMP_EN defined:
  - A free-running TS_W-bit counter runs, 0 on the first edge with reset low, incrementing every edge and wrapping.
  - On an edge where pending was 0, or ack is high in the same cycle, ts for that channel latches the counter value at the detection edge.
  - Later events while pending leave ts unchanged.
- Not defined: counter not built, ts tied to 0, ports unchanged.

## Test plan
- Reset with sig_in=4'b0101, then release, hold inputs → pending=0, count=0, irq=0, level_n=4'b1010 indefinitely.
- mode=8'b01_01_01_01, sig_in[0] 0→1 before edge 10 (edge 0 = first non-reset) → pending[0]=1, irq=1, count0=1 after edge 12; level_n[0]=0 after edge 11.
- mode ch1=11, toggle sig_in[1] every 4 cycles, 5 toggles → count1=5. Mode ch1=10 with the same stimulus → only falls counted. Mode 00 → count stays 0.
- CNT_W=2, 5 rising edges on ch2 → count2=3, overflow[2]=1. Then ack[2] pulse → pending, count, overflow all 0, irq=0.
- ack[0] in the same cycle as a detected edge with count0=7 → count0=1, pending[0]=1, overflow[0]=0.
- With EDGE_MONITOR_TIMESTAMP_EN, first edge detected at edge 12, second at 20 → ts0=12. ack, then edge detected at 30 → ts0=30. Without the macro → ts=0 throughout.

Source files
------------

// File: rtl/edge_monitor.sv
// Multi-channel edge-event monitor: synchronised inputs, per-channel edge mode, sticky pending/count/overflow.
// Optional per-channel timestamps are built when EDGE_MONITOR_TIMESTAMP_EN is defined.
module edge_monitor #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int TS_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        sig_in,
  input  logic [2*CHANNELS-1:0]      mode,
  input  logic [CHANNELS-1:0]        ack,
  output logic [CHANNELS-1:0]        pending,
  output logic [CHANNELS*CNT_W-1:0]  count,
  output logic [CHANNELS-1:0]        overflow,
  output logic                       irq,
  output logic [CHANNELS-1:0]        level_n,
  output logic [CHANNELS*TS_W-1:0]   ts
);

  logic [CHANNELS-1:0]             s1_q, s2_q, prev_q;
  logic [CHANNELS-1:0]             pending_q, pending_d;
  logic [CHANNELS-1:0]             overflow_q, overflow_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  count_q, count_d;
  logic [CHANNELS-1:0]             edgeEvt;

  // Reset loads the live input into every stage so a line already high at release raises no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= sig_in;
      s2_q       <= sig_in;
      prev_q     <= sig_in;
      pending_q  <= '0;
      overflow_q <= '0;
      count_q    <= '0;
    end else begin
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    edgeEvt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      edgeEvt[i] = (s2_q[i] & ~prev_q[i] & mode[2*i]) |
                   (~s2_q[i] & prev_q[i] & mode[2*i+1]);
    end
  end

  // An ack wipes the old record first, so an edge in the same cycle starts a fresh one.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ack[i]) begin
        pending_d[i]  = edgeEvt[i];
        overflow_d[i] = 1'b0;
        count_d[i]    = edgeEvt[i] ? CNT_W'(1) : '0;
      end else if (edgeEvt[i]) begin
        pending_d[i] = 1'b1;
        if (&count_q[i]) begin
          overflow_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign irq      = |pending_q;
  assign level_n  = ~s2_q;

`ifdef EDGE_MONITOR_TIMESTAMP_EN
  logic [TS_W-1:0]                tsCnt_q;
  logic [CHANNELS-1:0][TS_W-1:0]  ts_q, ts_d;

  // Only the first event after an ack (or after reset) captures the time.
  always_comb begin
    ts_d = ts_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (edgeEvt[i] && (!pending_q[i] || ack[i])) begin
        ts_d[i] = tsCnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tsCnt_q <= '0;
      ts_q    <= '0;
    end else begin
      tsCnt_q <= tsCnt_q + TS_W'(1);
      ts_q    <= ts_d;
    end
  end

  assign ts = ts_q;
`else
  assign ts = '0;
`endif

endmodule

// File: tb/tb_edge_monitor.sv
// Randomised scoreboard bench for edge_monitor: a sample-history reference model predicts every cycle's outputs.
// Expected responses are queued by the stimulus side and consumed by an independent monitor.
module tb_edge_monitor;

  localparam int CH = 4;
  localparam int CW = 3;
  localparam int TW = 16;

  logic                clk;
  logic                reset;
  logic [CH-1:0]       sig_in;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       ack;
  logic [CH-1:0]       pending;
  logic [CH*CW-1:0]    count;
  logic [CH-1:0]       overflow;
  logic                irq;
  logic [CH-1:0]       level_n;
  logic [CH*TW-1:0]    ts;

  edge_monitor #(.CHANNELS(CH), .CNT_W(CW), .TS_W(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .mode     (mode),
    .ack      (ack),
    .pending  (pending),
    .count    (count),
    .overflow (overflow),
    .irq      (irq),
    .level_n  (level_n),
    .ts       (ts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]     pend;
    logic [CH*CW-1:0]  cnt;
    logic [CH-1:0]     ovf;
    logic              irq;
    logic [CH-1:0]     lvl;
    logic [CH*TW-1:0]  ts;
  } expect_t;

  expect_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;
  bit stimDone   = 0;

  // Reference model: the sample history plus the per-channel record software would see.
  logic [CH-1:0] hist[$];
  bit  mPend[CH];
  bit  mOvf[CH];
  int  mCnt[CH];
  int  mTs[CH];
  int  tick;

  logic [CH-1:0]   sigDrv;
  logic [CH-1:0]   ackDrv;
  logic [2*CH-1:0] modeDrv;
  int              holdLeft[CH];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Predicts the DUT state after the coming posedge, given the inputs now driven.
  task automatic modelEdge(input bit doReset);
    expect_t e;
    int maxCnt = (1 << CW) - 1;
    logic [CH-1:0] newV, oldV;
    e = '0;
    if (doReset) begin
      hist.delete();
      repeat (3) hist.push_back(sig_in);
      for (int c = 0; c < CH; c++) begin
        mPend[c] = 0; mOvf[c] = 0; mCnt[c] = 0; mTs[c] = 0;
      end
      tick = 0;
    end else begin
      newV = hist[hist.size()-2];
      oldV = hist[hist.size()-3];
      for (int c = 0; c < CH; c++) begin
        bit ev;
        ev = (newV[c] && !oldV[c] && mode[2*c]) || (!newV[c] && oldV[c] && mode[2*c+1]);
        if (ack[c]) begin
          mPend[c] = ev;
          mOvf[c]  = 0;
          mCnt[c]  = ev ? 1 : 0;
          if (ev) mTs[c] = tick % (1 << TW);
        end else if (ev) begin
          if (!mPend[c]) mTs[c] = tick % (1 << TW);
          mPend[c] = 1;
          if (mCnt[c] == maxCnt) mOvf[c] = 1;
          else mCnt[c] = mCnt[c] + 1;
        end
      end
      tick++;
      hist.push_back(sig_in);
      void'(hist.pop_front());
    end
    for (int c = 0; c < CH; c++) begin
      e.pend[c] = mPend[c];
      e.ovf[c]  = mOvf[c];
      e.cnt[c*CW +: CW] = CW'(mCnt[c]);
`ifdef EDGE_MONITOR_TIMESTAMP_EN
      e.ts[c*TW +: TW] = TW'(mTs[c]);
`endif
    end
    e.irq = |e.pend;
    e.lvl = ~hist[hist.size()-2];
    expQ.push_back(e);
  endtask

  // One cycle of stimulus; ackOneIn = 0 disables acks, hold freezes the inputs.
  task automatic applyStimulus(input bit doReset, input int ackOneIn, input bit hold);
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      if (!hold) begin
        if (holdLeft[c] == 0) begin
          sigDrv[c]   = ~sigDrv[c];
          holdLeft[c] = $urandom_range(1, 6);
        end else begin
          holdLeft[c]--;
        end
      end
      ackDrv[c] = (ackOneIn > 0) && ($urandom_range(0, ackOneIn - 1) == 0);
    end
    if (!hold && $urandom_range(0, 49) == 0) modeDrv = 2*CH'($urandom);
    reset  = doReset;
    sig_in = sigDrv;
    ack    = ackDrv;
    mode   = modeDrv;
    modelEdge(doReset);
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pending",  128'(pending),  128'(e.pend));
        checkOutput("count",    128'(count),    128'(e.cnt));
        checkOutput("overflow", 128'(overflow), 128'(e.ovf));
        checkOutput("irq",      128'(irq),      128'(e.irq));
        checkOutput("level_n",  128'(level_n),  128'(e.lvl));
        checkOutput("ts",       128'(ts),       128'(e.ts));
      end
    end
  end

  initial begin : stimulus
    int waitCycles;
    reset   = 1'b1;
    sig_in  = 4'b0101;
    ack     = '0;
    mode    = 8'hFF;
    sigDrv  = 4'b0101;
    ackDrv  = '0;
    modeDrv = 8'hFF;
    for (int c = 0; c < CH; c++) holdLeft[c] = $urandom_range(1, 6);

    repeat (2) applyStimulus(1'b1, 0, 1'b1);
    repeat (12) applyStimulus(1'b0, 0, 1'b1);
    repeat (600) applyStimulus(1'b0, 12, 1'b0);
    modeDrv = 8'hFF;
    repeat (150) applyStimulus(1'b0, 0, 1'b0);
    repeat (2) applyStimulus(1'b1, 0, 1'b0);
    repeat (400) applyStimulus(1'b0, 4, 1'b0);
    repeat (100) applyStimulus(1'b0, 2, 1'b0);

    @(negedge clk);
    ack = '0;
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    checkOutput("drain", 128'(expQ.size()), 128'(0));
    stimDone = 1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
